// File: rtl/imem_loader_if.sv
// Boot-load write stream and core fetch port of the instruction-memory stage.
// The master side is the generator/core, the slave side is imem_loader.
interface imem_loader_if;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        fetch_en;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;

  modport master (
    output ld_we, ld_addr, ld_data, fetch_en, fetch_pc,
    input  fetch_instr
  );

  modport slave (
    input  ld_we, ld_addr, ld_data, fetch_en, fetch_pc,
    output fetch_instr
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory filled from the boot-time generator stream; releases the
// core from reset once loading ends, then serves fetches with registered reads.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] END_MARK    = 32'h000fd073,
  parameter int unsigned IDLE_LIMIT  = 256,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  output logic         core_rst,
  output logic         load_done,
  output logic [15:0]  word_count,
  output logic         load_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned IW = $clog2(IDLE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic            drain_cnt_r;
  logic [IW-1:0]   idle_cnt_r;
  logic            seen_wr_r;
  logic            wr_ok_s;
  logic            wr_bad_s;
  logic            wc_bump_s;
  logic            fetch_ok_s;
  logic [31:0]     idx_p1_s;
  logic [31:0]     mem [DEPTH_WORDS];

  // Decode the load stream, fetch validity and the next state.
  always_comb begin
    next_state_s = state_r;
    wr_ok_s      = 1'b0;
    wr_bad_s     = 1'b0;
    idx_p1_s     = {2'b00, bus.ld_addr[31:2]} + 32'd1;
    fetch_ok_s   = (bus.fetch_pc[1:0] == 2'b00) &&
                   ({2'b00, bus.fetch_pc[31:2]} < {16'd0, word_count});
    case (state_r)
      S_LOAD: begin
        if (bus.ld_we) begin
          if ((bus.ld_addr[1:0] == 2'b00) &&
              ({2'b00, bus.ld_addr[31:2]} < 32'(DEPTH_WORDS))) begin
            wr_ok_s = 1'b1;
            if (bus.ld_data == END_MARK) begin
              next_state_s = S_DRAIN;
            end else begin
              next_state_s = S_LOAD;
            end
          end else begin
            wr_bad_s = 1'b1;
          end
        end else if (seen_wr_r && (idle_cnt_r == IW'(IDLE_LIMIT - 1))) begin
          // Counter reads IDLE_LIMIT-1 here, so DRAIN lands IDLE_LIMIT edges after the last write.
          next_state_s = S_DRAIN;
        end else begin
          next_state_s = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_r) begin
          next_state_s = S_RUN;
        end else begin
          next_state_s = S_DRAIN;
        end
      end
      S_RUN:   next_state_s = S_RUN;
      default: next_state_s = S_LOAD;
    endcase
    wc_bump_s = wr_ok_s && (idx_p1_s > {16'd0, word_count});
  end

  // Control state, load bookkeeping and registered core release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_LOAD;
      drain_cnt_r <= 1'b0;
      idle_cnt_r  <= '0;
      seen_wr_r   <= 1'b0;
      word_count  <= 16'd0;
      load_err    <= 1'b0;
      core_rst    <= 1'b1;
      load_done   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      drain_cnt_r <= (state_r == S_DRAIN) ? ~drain_cnt_r : 1'b0;
      if (state_r == S_LOAD) begin
        if (bus.ld_we) begin
          idle_cnt_r <= '0;
        end else if (seen_wr_r) begin
          idle_cnt_r <= idle_cnt_r + IW'(1);
        end
      end
      seen_wr_r <= seen_wr_r | wr_ok_s;
      if (wc_bump_s) begin
        word_count <= idx_p1_s[15:0];
      end
      load_err  <= load_err | wr_bad_s;
      core_rst  <= (next_state_s != S_RUN);
      load_done <= (next_state_s == S_RUN);
    end
  end

  // Instruction storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s && !rst) begin
      mem[bus.ld_addr[AW+1:2]] <= bus.ld_data;
    end
  end

  // Registered fetch port; stalls hold the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fetch_instr <= NOP_WORD;
    end else if (state_r == S_RUN) begin
      if (bus.fetch_en) begin
        bus.fetch_instr <= fetch_ok_s ? mem[bus.fetch_pc[AW+1:2]] : NOP_WORD;
      end
    end else begin
      bus.fetch_instr <= NOP_WORD;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load/drain/run sequencing, error drops,
// idle timeout and fetch behaviour checked against a reference memory model.
module tb_imem_loader;
  localparam int unsigned DEPTH      = 1024;
  localparam logic [31:0] END_MARK   = 32'h000fd073;
  localparam int unsigned IDLE_LIMIT = 256;
  localparam logic [31:0] NOP        = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        core_rst;
  logic        load_done;
  logic [15:0] word_count;
  logic        load_err;

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH_WORDS(DEPTH),
    .END_MARK   (END_MARK),
    .IDLE_LIMIT (IDLE_LIMIT),
    .NOP_WORD   (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .core_rst  (core_rst),
    .load_done (load_done),
    .word_count(word_count),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          model_wc;
  logic        model_err;
  logic        model_loading;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    model_wc      = 0;
    model_err     = 1'b0;
    model_loading = 1'b1;
  endtask

  // One write strobe, with the reference model applying the acceptance rules.
  task automatic ld_write(input logic [31:0] addr, input logic [31:0] data);
    bus.ld_we   = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    tick();
    bus.ld_we = 1'b0;
    if (model_loading) begin
      if (addr[1:0] != 2'b00 || addr[31:2] >= 30'(DEPTH)) begin
        model_err = 1'b1;
      end else begin
        model_mem[addr[31:2]] = data;
        if (int'(addr[31:2]) + 1 > model_wc) model_wc = int'(addr[31:2]) + 1;
        if (data == END_MARK) model_loading = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] model_fetch(input logic [31:0] pc);
    if (pc[1:0] == 2'b00 && int'(pc[31:2]) < model_wc) return model_mem[pc[31:2]];
    return NOP;
  endfunction

  // Drive one fetch cycle; the expectation is queued before the edge and popped after it.
  task automatic fstep(input logic en, input logic [31:0] pc, input logic [31:0] expv, input string tag);
    bus.fetch_en = en;
    bus.fetch_pc = pc;
    exp_q.push_back(expv);
    tick();
    chk(tag, bus.fetch_instr, exp_q.pop_front());
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_wc"},  {16'd0, word_count}, 32'(model_wc));
    chk({tag, "_err"}, {31'd0, load_err},   {31'd0, model_err});
  endtask

  initial begin
    rst          = 1'b1;
    bus.ld_we    = 1'b0;
    bus.ld_addr  = 32'd0;
    bus.ld_data  = 32'd0;
    bus.fetch_en = 1'b0;
    bus.fetch_pc = 32'd0;
    model_reset();
    tick();
    tick();
    chk("rst_fetch",     bus.fetch_instr, NOP);
    chk("rst_core_rst",  {31'd0, core_rst},  32'd1);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk_status("rst");
    rst = 1'b0;

    // Load 1: 29 words, two illegal writes, then END_MARK at 0x74.
    for (int i = 0; i < 29; i++) begin
      ld_write(32'(i * 4), (i == 0) ? 32'hfe010113 : 32'h1000_0000 + 32'(i));
    end
    chk_status("l1_pre");
    ld_write(32'h0000_0006, 32'hbad0_0006);
    ld_write(32'(DEPTH * 4), 32'hbad0_1000);
    chk_status("l1_bad");
    chk("l1_bad_err_set", {31'd0, load_err}, 32'd1);
    ld_write(32'h0000_0074, END_MARK);
    chk_status("l1_end");
    chk("l1_end_core_rst", {31'd0, core_rst}, 32'd1);
    // Writes during DRAIN and on the DRAIN->RUN edge must be ignored.
    bus.ld_we   = 1'b1;
    bus.ld_addr = 32'd0;
    bus.ld_data = 32'hdeadbeef;
    fstep(1'b1, 32'd0, NOP, "drain1_fetch");
    chk("drain1_core_rst", {31'd0, core_rst}, 32'd1);
    fstep(1'b1, 32'd0, NOP, "drain2_fetch");
    chk("run_core_rst",  {31'd0, core_rst},  32'd0);
    chk("run_load_done", {31'd0, load_done}, 32'd1);
    fstep(1'b1, 32'd0, 32'hfe010113, "run_first_fetch");
    bus.ld_we = 1'b0;
    fstep(1'b1, 32'd0, 32'hfe010113, "run_no_overwrite");
    chk_status("l1_run");
    fstep(1'b1, 32'h10, model_fetch(32'h10), "fetch_0x10");
    fstep(1'b1, 32'h74, END_MARK,            "fetch_end");
    fstep(1'b1, 32'h78, NOP,                 "fetch_beyond_wc");
    fstep(1'b1, 32'h02, NOP,                 "fetch_misaligned");
    // Stall: output held while fetch_pc moves.
    fstep(1'b1, 32'h08, model_fetch(32'h08), "stall_pre");
    fstep(1'b0, 32'h0c, model_fetch(32'h08), "stall_1");
    fstep(1'b0, 32'h10, model_fetch(32'h08), "stall_2");
    fstep(1'b0, 32'h14, model_fetch(32'h08), "stall_3");
    fstep(1'b1, 32'h1c, model_fetch(32'h1c), "stall_resume");

    // Reset from RUN.
    rst = 1'b1;
    bus.fetch_en = 1'b0;
    tick();
    model_reset();
    chk("rr_core_rst",  {31'd0, core_rst},  32'd1);
    chk("rr_load_done", {31'd0, load_done}, 32'd0);
    chk("rr_fetch",     bus.fetch_instr,    NOP);
    chk_status("rr");
    rst = 1'b0;

    // Load 2: repeated writes to 0x7c before the end mark.
    for (int i = 0; i < 6; i++) ld_write(32'(i * 4), 32'h2000_0000 + 32'(i));
    for (int r = 0; r < 10; r++) ld_write(32'h7c, 32'h0aa0_0000 + 32'(r));
    chk("rep_wc", {16'd0, word_count}, 32'd32);
    ld_write(32'h80, END_MARK);
    tick();
    chk("l2_core_rst_drain", {31'd0, core_rst}, 32'd1);
    tick();
    chk("l2_core_rst_run", {31'd0, core_rst}, 32'd0);
    chk_status("l2_run");
    fstep(1'b1, 32'h7c, 32'h0aa00009, "rep_last_value");
    fstep(1'b1, 32'h14, 32'h20000005, "l2_fetch_0x14");
    fstep(1'b1, 32'h80, END_MARK,     "l2_fetch_end");

    // Load 3: no timeout before the first write, then idle timeout after 5 writes.
    rst = 1'b1;
    bus.fetch_en = 1'b0;
    tick();
    model_reset();
    rst = 1'b0;
    repeat (IDLE_LIMIT + 40) tick();
    chk("no_early_timeout", {31'd0, core_rst}, 32'd1);
    for (int i = 0; i < 5; i++) ld_write(32'(i * 4), 32'h3000_0000 + 32'(i));
    repeat (IDLE_LIMIT + 1) tick();
    chk("idle_drain_core_rst", {31'd0, core_rst}, 32'd1);
    tick();
    chk("idle_run_core_rst",  {31'd0, core_rst},  32'd0);
    chk("idle_run_load_done", {31'd0, load_done}, 32'd1);
    chk_status("l3_run");
    fstep(1'b1, 32'h14, NOP,          "idle_fetch_0x14");
    fstep(1'b1, 32'h10, 32'h30000004, "idle_fetch_0x10");
    fstep(1'b1, 32'h00, 32'h30000000, "idle_fetch_0x00");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
